instr_mem_loader: RTL
=====================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, word-address width (capacity 2^ADDR_WIDTH = 256 words).
REQ-002 SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, end-of-program marker word.
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_start  input  1  one-cycle pulse requesting a new program load.
REQ-006 SHALL have port i_rx_data  input  8  incoming program byte.
REQ-007 SHALL have port i_rx_valid  input  1  i_rx_data valid this cycle.
REQ-008 SHALL have port o_rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port o_wr_en  output  1  instruction-memory write strobe.
REQ-010 SHALL have port o_wr_addr  output  ADDR_WIDTH  word address, 4-byte aligned, matching the read side's i_pc[31:2] indexing.
REQ-011 SHALL have port o_wr_data  output  32  instruction word to write.
REQ-012 SHALL have port o_busy  output  1  load in progress.
REQ-013 SHALL have port o_done  output  1  program loaded, HALT_WORD written.
REQ-014 SHALL have port o_error  output  1  memory filled without HALT_WORD.
REQ-015 SHALL have port o_word_count  output  ADDR_WIDTH+1  words written in current load.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, WRITE, DONE, ERROR.
REQ-017 Byte transfer SHALL occur only on a cycle with i_rx_valid=1 and o_rx_ready=1; i_rx_data ignored otherwise.
REQ-018 o_rx_ready SHALL be 1 only in COLLECT, 0 in all other states.
REQ-019 IDLE: outputs idle; i_start=1 -> COLLECT, clearing byte index, o_wr_addr, o_word_count, o_done, o_error.
REQ-020 COLLECT: accepted byte k (k=0..3) SHALL be placed in word bits [8k+7:8k] (little-endian); acceptance of byte 3 -> WRITE.
REQ-021 WRITE SHALL last exactly one cycle with o_wr_en=1, o_wr_addr=current address, o_wr_data=assembled word; write latency is 1 cycle after the 4th byte is accepted.
REQ-022 Every written word, including HALT_WORD, SHALL increment o_word_count by 1 in the cycle after WRITE.
REQ-023 After WRITE: word==HALT_WORD -> DONE; else if o_wr_addr==2^ADDR_WIDTH-1 -> ERROR; else o_wr_addr+1 and -> COLLECT with byte index 0.
REQ-024 o_wr_addr SHALL never wrap; no write beyond address 2^ADDR_WIDTH-1.
REQ-025 DONE: o_done=1; ERROR: o_error=1; both sticky until i_start (-> COLLECT, restart at address 0) or reset.
REQ-026 o_busy SHALL be 1 in COLLECT and WRITE, 0 otherwise.
REQ-027 i_start SHALL be ignored in COLLECT and WRITE.
REQ-028 o_wr_en SHALL be 0 in every state except WRITE.
REQ-029 o_wr_addr and o_wr_data SHALL be registered and hold their last values when o_wr_en=0.
REQ-030 Stalls (i_rx_valid=0) in COLLECT SHALL hold the partial word and byte index indefinitely.

Reset
REQ-031 i_reset=1 SHALL immediately force IDLE, o_rx_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_error=0, o_word_count=0.
REQ-032 Reset mid-load SHALL discard any partial word; no write strobe SHALL be produced from pre-reset bytes.

Verification
REQ-033 Start, bytes 01 00 00 00 02 00 00 00 FF FF FF FF -> writes (0,00000001),(1,00000002),(2,FFFFFFFF), o_done=1, o_word_count=3.
REQ-034 Bytes with i_rx_valid gaps of 0-5 cycles between bytes -> identical writes to REQ-033, o_wr_en high exactly 3 single cycles.
REQ-035 256 non-halt words (value = address) -> last write at address 255, o_error=1, o_done=0, o_word_count=256, no 257th strobe.
REQ-036 Assert i_reset after 2 bytes of word 1 -> all outputs reset values; new start plus 4 bytes AA BB CC DD -> write (0,DDCCBBAA).
REQ-037 i_start pulsed during COLLECT -> ignored, address sequence unchanged; i_start in DONE -> reload begins at address 0, o_done cleared.
REQ-038 Byte 4 accepted at cycle N -> o_wr_en=1 at N+1 only, o_rx_ready=0 at N+1, 1 again at N+2.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Assembles little-endian bytes from a serial stream into 32-bit words and writes them
// into instruction memory. The load stops at HALT_WORD, or flags an error when memory fills first.
module instr_mem_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [31:0]           o_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERROR} state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_idx;
  logic [23:0] partial;
  logic        accept;
  logic        last_addr;
  logic        is_halt;

  assign accept    = (state == COLLECT) && i_rx_valid;
  assign last_addr = (o_wr_addr == '1);
  assign is_halt   = (o_wr_data == HALT_WORD);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    o_rx_ready = 1'b0;
    o_wr_en    = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_error    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = COLLECT;
      end
      COLLECT: begin
        o_rx_ready = 1'b1;
        o_busy     = 1'b1;
        if (accept && byte_idx == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        o_wr_en = 1'b1;
        o_busy  = 1'b1;
        if (is_halt)        state_nxt = DONE;
        else if (last_addr) state_nxt = ERROR;
        else                state_nxt = COLLECT;
      end
      DONE: begin
        o_done = 1'b1;
        if (i_start) state_nxt = COLLECT;
      end
      ERROR: begin
        o_error = 1'b1;
        if (i_start) state_nxt = COLLECT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The final byte is merged straight into o_wr_data, so the word is presented in the WRITE cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      byte_idx     <= '0;
      partial      <= '0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_word_count <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (i_start) begin
            byte_idx     <= '0;
            o_wr_addr    <= '0;
            o_word_count <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            case (byte_idx)
              2'd0:    partial[7:0]   <= i_rx_data;
              2'd1:    partial[15:8]  <= i_rx_data;
              2'd2:    partial[23:16] <= i_rx_data;
              default: o_wr_data      <= {i_rx_data, partial};
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
        end
        WRITE: begin
          o_word_count <= o_word_count + 1'b1;
          if (!is_halt && !last_addr) o_wr_addr <= o_wr_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
